// File: rtl/bcd_to_bin_seq_if.sv
// Request/result handshake bundle for the BCD-to-binary converter.
// The master side issues packed BCD digits and bounds; the slave side returns the clamped value.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int W_OUT  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIGITS*4-1:0]   in_digits;
  logic [W_OUT-1:0]      min_val;
  logic [W_OUT-1:0]      max_val;
  logic                  out_valid;
  logic                  out_ready;
  logic [W_OUT-1:0]      out_value;
  logic                  out_err_digit;
  logic                  out_clamped;

  modport master (
    output in_valid, in_digits, min_val, max_val, out_ready,
    input  in_ready, out_valid, out_value, out_err_digit, out_clamped
  );

  modport slave (
    input  in_valid, in_digits, min_val, max_val, out_ready,
    output in_ready, out_valid, out_value, out_err_digit, out_clamped
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: accumulates digits MSD first (acc*10 + d),
// then range-checks against caller bounds and returns a clamped value over valid/ready.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int W_OUT  = 8
) (
  input  logic            clk,
  input  logic            nreset,
  bcd_to_bin_seq_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ACC_W = W_OUT + 4;

  typedef enum logic [1:0] {IDLE, CONVERT, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIGITS*4-1:0] digits_q, digits_d;
  logic [W_OUT-1:0]    min_q, min_d;
  logic [W_OUT-1:0]    max_q, max_d;
  logic [W_OUT-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [W_OUT-1:0]    value_q, value_d;
  logic                err_out_q, err_out_d;
  logic                clamp_q, clamp_d;

  logic [3:0]          nib;
  logic [3:0]          d_eff;
  logic [ACC_W-1:0]    sum;
  logic                over;

  // acc*10 + d using two shifts; the 4 guard bits expose any overflow past W_OUT
  function automatic logic [ACC_W-1:0] mul10_add(input logic [W_OUT-1:0] a, input logic [3:0] d);
    logic [ACC_W-1:0] ax;
    ax = {4'b0000, a};
    return (ax << 3) + (ax << 1) + {{W_OUT{1'b0}}, d};
  endfunction

  // Result as {value, err_digit, clamped}; a bad digit outranks overflow and range checks
  function automatic logic [W_OUT+1:0] check_range(
    input logic [W_OUT-1:0] a,
    input logic             ovf,
    input logic             err,
    input logic [W_OUT-1:0] lo,
    input logic [W_OUT-1:0] hi
  );
    if (err)         return {lo, 1'b1, 1'b0};
    else if (ovf)    return {hi, 1'b0, 1'b1};
    else if (a < lo) return {lo, 1'b0, 1'b1};
    else if (a > hi) return {hi, 1'b0, 1'b1};
    else             return {a,  1'b0, 1'b0};
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      min_q     <= '0;
      max_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      value_q   <= '0;
      err_out_q <= 1'b0;
      clamp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      min_q     <= min_d;
      max_q     <= max_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      value_q   <= value_d;
      err_out_q <= err_out_d;
      clamp_q   <= clamp_d;
    end
  end

  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) nib = digits_q[k*4 +: 4];
    end
    d_eff = (nib > 4'd9) ? 4'd0 : nib;
    sum   = mul10_add(acc_q, d_eff);
    over  = ovf_q || (sum[ACC_W-1:W_OUT] != 4'd0);
  end

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    min_d     = min_q;
    max_d     = max_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    value_d   = value_q;
    err_out_d = err_out_q;
    clamp_d   = clamp_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          digits_d = bus.in_digits;
          min_d    = bus.min_val;
          max_d    = bus.max_val;
          acc_d    = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          idx_d    = IDX_W'(DIGITS - 1);
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        if (nib > 4'd9) err_d = 1'b1;
        ovf_d = over;
        acc_d = over ? {W_OUT{1'b1}} : sum[W_OUT-1:0];
        if (idx_q == '0) state_d = CHECK;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      CHECK: begin
        {value_d, err_out_d, clamp_d} = check_range(acc_q, ovf_q, err_q, min_q, max_q);
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_value     = value_q;
  assign bus.out_err_digit = err_out_q;
  assign bus.out_clamped   = clamp_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 2-digit and a 3-digit instance checked every cycle against
// an arithmetic reference model, plus directed cases with hand-computed results.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.DIGITS(2), .W_OUT(8)) if0 ();
  bcd_to_bin_seq_if #(.DIGITS(3), .W_OUT(8)) if1 ();

  bcd_to_bin_seq #(.DIGITS(2), .W_OUT(8)) dut0 (.clk(clk), .nreset(nreset), .bus(if0));
  bcd_to_bin_seq #(.DIGITS(3), .W_OUT(8)) dut1 (.clk(clk), .nreset(nreset), .bus(if1));

  // bench-side drive and observe arrays, index 0 = 2-digit, 1 = 3-digit
  logic        iv   [2];
  logic [15:0] dg   [2];
  logic [7:0]  mn   [2];
  logic [7:0]  mx   [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [7:0]  oval [2];
  logic        oe   [2];
  logic        oc   [2];

  assign if0.in_valid  = iv[0];
  assign if0.in_digits = dg[0][7:0];
  assign if0.min_val   = mn[0];
  assign if0.max_val   = mx[0];
  assign if0.out_ready = ordy[0];
  assign if1.in_valid  = iv[1];
  assign if1.in_digits = dg[1][11:0];
  assign if1.min_val   = mn[1];
  assign if1.max_val   = mx[1];
  assign if1.out_ready = ordy[1];

  assign ir[0] = if0.in_ready;   assign ir[1] = if1.in_ready;
  assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;
  assign oval[0] = if0.out_value; assign oval[1] = if1.out_value;
  assign oe[0] = if0.out_err_digit; assign oe[1] = if1.out_err_digit;
  assign oc[0] = if0.out_clamped;   assign oc[1] = if1.out_clamped;

  int n_cmp = 0;
  int n_bad = 0;
  int timeouts = 0;
  logic chk_en = 1'b0;
  logic final_chk = 1'b0;

  logic lit_on = 1'b0;
  int   lit_i, lit_val, lit_err, lit_clamp, lit_lat, lit_lat_exp;

  function automatic int ndig(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // Decimal value of the digits with bad nibbles counted as 0, then the bound rules.
  // Returns {value[7:0], err_digit, clamped}.
  function automatic logic [9:0] ref_model(input logic [15:0] d, input int nd,
                                           input logic [7:0] lo, input logic [7:0] hi);
    int v;
    int dd;
    bit e;
    logic [7:0] r;
    v = 0;
    e = 0;
    for (int k = nd - 1; k >= 0; k--) begin
      dd = int'(d[k*4 +: 4]);
      if (dd > 9) begin
        e  = 1;
        dd = 0;
      end
      v = v * 10 + dd;
    end
    r = v[7:0];
    if (e)                 return {lo, 2'b10};
    if (v > 255)           return {hi, 2'b01};
    if (v < int'(lo))      return {lo, 2'b01};
    if (v > int'(hi))      return {hi, 2'b01};
    return {r, 2'b00};
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 9) == 0) r[k*4 +: 4] = 4'($urandom_range(10, 15));
      else                           r[k*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Reference model: idle until accepted, result appears DIGITS+2 cycles after the
  // accept cycle, held until out_ready is seen.
  logic       m_busy [2];
  int         m_cnt  [2];
  logic       e_valid[2];
  logic [9:0] e_res  [2];
  logic [9:0] p_res  [2];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_cnt[i]   <= 0;
        e_valid[i] <= 1'b0;
        e_res[i]   <= '0;
        p_res[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (iv[i]) begin
            m_busy[i] <= 1'b1;
            m_cnt[i]  <= ndig(i) + 1;
            p_res[i]  <= ref_model(dg[i], ndig(i), mn[i], mx[i]);
          end
        end else if (m_cnt[i] != 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            e_valid[i] <= 1'b1;
            e_res[i]   <= p_res[i];
          end
        end else if (ordy[i]) begin
          e_valid[i] <= 1'b0;
          m_busy[i]  <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // The single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready[%0d]", i),      int'(ir[i]),   int'(!m_busy[i]));
        chk($sformatf("out_valid[%0d]", i),     int'(ov[i]),   int'(e_valid[i]));
        chk($sformatf("out_value[%0d]", i),     int'(oval[i]), int'(e_res[i][9:2]));
        chk($sformatf("out_err_digit[%0d]", i), int'(oe[i]),   int'(e_res[i][1]));
        chk($sformatf("out_clamped[%0d]", i),   int'(oc[i]),   int'(e_res[i][0]));
      end
      if (lit_on) begin
        chk($sformatf("lit_value[%0d]", lit_i),   int'(oval[lit_i]), lit_val);
        chk($sformatf("lit_err[%0d]", lit_i),     int'(oe[lit_i]),   lit_err);
        chk($sformatf("lit_clamped[%0d]", lit_i), int'(oc[lit_i]),   lit_clamp);
        chk($sformatf("lit_latency[%0d]", lit_i), lit_lat,           lit_lat_exp);
      end
      if (final_chk) begin
        chk("timeouts", timeouts, 0);
        chk("pin_model_21",  int'(ref_model(16'h0021, 2, 8'd1, 8'd99)),   {8'd21, 2'b00});
        chk("pin_model_999", int'(ref_model(16'h0999, 3, 8'd0, 8'd200)),  {8'd200, 2'b01});
        chk("pin_model_1A",  int'(ref_model(16'h001A, 2, 8'd4, 8'd99)),   {8'd4, 2'b10});
        chk("pin_model_inv", int'(ref_model(16'h0050, 2, 8'd60, 8'd40)),  {8'd60, 2'b01});
      end
    end
  end

  task automatic send_wait(input int i, input logic [15:0] d, input logic [7:0] lo,
                           input logic [7:0] hi, output int lat, output bit ok);
    ok  = 0;
    lat = 0;
    for (int c = 0; c < 50 && !ir[i]; c++) @(posedge clk) #1;
    iv[i] = 1'b1;
    dg[i] = d;
    mn[i] = lo;
    mx[i] = hi;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk) #1;
      lat++;
      if (lat == 1) iv[i] = 1'b0;
      if (ov[i]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      iv[i] = 1'b0;
      timeouts++;
      $display("FAIL timeout[%0d]: got no out_valid expected one within 30 cycles", i);
    end
  endtask

  task automatic directed(input int i, input logic [15:0] d, input logic [7:0] lo,
                          input logic [7:0] hi, input int ev, input int ee, input int ec);
    int lat;
    bit ok;
    send_wait(i, d, lo, hi, lat, ok);
    if (ok) begin
      lit_i       = i;
      lit_val     = ev;
      lit_err     = ee;
      lit_clamp   = ec;
      lit_lat     = lat;
      lit_lat_exp = ndig(i) + 2;
      lit_on      = 1'b1;
      @(posedge clk) #1;
      lit_on = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; dg[i] = '0; mn[i] = '0; mx[i] = '0; ordy[i] = 1'b1;
    end
    nreset = 1'b1;
    #2 nreset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk) #1;

    directed(0, 16'h0021, 8'd1, 8'd99, 21, 0, 0);
    directed(0, 16'h0000, 8'd1, 8'd20, 1, 0, 1);
    directed(0, 16'h0035, 8'd1, 8'd20, 20, 0, 1);
    directed(0, 16'h001A, 8'd4, 8'd99, 4, 1, 0);
    directed(0, 16'h0050, 8'd60, 8'd40, 60, 0, 1);
    directed(1, 16'h0999, 8'd0, 8'd200, 200, 0, 1);
    directed(1, 16'h0255, 8'd0, 8'd255, 255, 0, 0);
    directed(1, 16'h0256, 8'd0, 8'd255, 255, 0, 1);
    directed(1, 16'h09F9, 8'd7, 8'd100, 7, 1, 0);

    // backpressure with an ignored request during the held result
    ordy[0] = 1'b0;
    send_wait(0, 16'h0058, 8'd0, 8'd99, lat, ok);
    if (ok) begin
      lit_i = 0; lit_val = 58; lit_err = 0; lit_clamp = 0; lit_lat = lat; lit_lat_exp = 4;
      lit_on = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 1) begin
          iv[0] = 1'b1; dg[0] = 16'h0007; mn[0] = 8'd0; mx[0] = 8'd99;
        end
        @(posedge clk) #1;
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk) #1;
      lit_on  = 1'b0;
      ordy[0] = 1'b0;
      repeat (6) @(posedge clk) #1;
    end
    ordy[0] = 1'b1;

    // reset during the second conversion cycle
    iv[0] = 1'b1; dg[0] = 16'h0042; mn[0] = 8'd0; mx[0] = 8'd99;
    @(posedge clk) #1;
    iv[0] = 1'b0;
    @(posedge clk) #1;
    nreset = 1'b0;
    repeat (2) @(posedge clk) #1;
    nreset = 1'b1;
    repeat (8) @(posedge clk) #1;
    directed(0, 16'h0013, 8'd0, 8'd99, 13, 0, 0);

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk) #1;
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom_range(0, 2) == 0);
        dg[i]   = rand_digits();
        mn[i]   = 8'($urandom_range(0, 100));
        mx[i]   = 8'($urandom_range(0, 255));
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (20) @(posedge clk) #1;

    final_chk = 1'b1;
    @(posedge clk) #1;
    final_chk = 1'b0;
    @(posedge clk) #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
